// File: rtl/sser_pkg.sv
// Shared types and constants for the serial-register read sequencer.
// Holds the FSM encoding, the legal address window and small helpers.
package sser_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 10;

  // Only the BA13=0 / BA12=1 window maps onto the serial register.
  localparam logic LEGAL_BA13 = 1'b0;
  localparam logic LEGAL_BA12 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } sser_state_t;

  function automatic logic is_legal_addr(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1] == LEGAL_BA13) && (addr[ADDR_W-2] == LEGAL_BA12);
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? NUM_PORTS'(2) : NUM_PORTS'(1);
  endfunction

endpackage

// File: rtl/sser_read_sequencer_if.sv
// Requester-side handshake for the read sequencer: two request ports
// sharing one response data bus.
interface sser_req_if #(
  parameter int DATA_W = 8
);
  import sser_pkg::*;

  logic [NUM_PORTS-1:0] req_valid;
  logic [ADDR_W-1:0]    req_addr0;
  logic [ADDR_W-1:0]    req_addr1;
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] rsp_valid;
  logic [NUM_PORTS-1:0] rsp_err;
  logic [DATA_W-1:0]    rsp_data;

  modport master (
    output req_valid, req_addr0, req_addr1,
    input  req_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1,
    output req_ready, rsp_valid, rsp_err, rsp_data
  );

endinterface

// File: rtl/sser_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a
// grant is actually taken (advance), and resets so that port 0 wins first.
module sser_rr_arb
  import sser_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (advance) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/sser_read_sequencer.sv
// Arbitrates two read requesters onto the serial-register bus: address
// setup, DATA_W-bit MSB-first shift-in, one-cycle response, one idle gap.
module sser_read_sequencer
  import sser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sser_req_if.slave         host,
  output logic              sser_n,
  output logic [ADDR_W-1:0] ba,
  output logic              br_w,
  input  logic              sdrd
);

  localparam int CNT_W = 5;

  sser_state_t          state_reg;
  logic                 port_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DATA_W-1:0]    shift_reg;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] ready;
  logic                 accept;
  logic                 sel_port;
  logic [ADDR_W-1:0]    sel_addr;

  sser_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (host.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready depends on the live request, so it is decoded from the state.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    assign ready[gi] = (state_reg == IDLE) && grant[gi];
  end

  assign host.req_ready = ready;
  assign accept         = |(host.req_valid & ready);
  assign sel_port       = grant[1];
  assign sel_addr       = sel_port ? host.req_addr1 : host.req_addr0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      port_reg       <= 1'b0;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      sser_n         <= 1'b1;
      ba             <= '0;
      br_w           <= 1'b0;
      host.rsp_valid <= '0;
      host.rsp_err   <= '0;
      host.rsp_data  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            port_reg <= sel_port;
            cnt_reg  <= '0;
            if (is_legal_addr(sel_addr)) begin
              state_reg <= SETUP;
              ba        <= sel_addr;
              br_w      <= 1'b1;
            end else begin
              // Illegal window: answer at once, never touch the bus.
              state_reg      <= DONE;
              host.rsp_valid <= port_onehot(sel_port);
              host.rsp_err   <= port_onehot(sel_port);
              host.rsp_data  <= '0;
            end
          end
        end
        SETUP: begin
          if (cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
            state_reg <= SHIFT;
            sser_n    <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[DATA_W-2:0], sdrd};
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            // Last bit goes straight into the response word.
            state_reg      <= DONE;
            sser_n         <= 1'b1;
            ba             <= '0;
            br_w           <= 1'b0;
            host.rsp_valid <= port_onehot(port_reg);
            host.rsp_err   <= '0;
            host.rsp_data  <= {shift_reg[DATA_W-2:0], sdrd};
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          host.rsp_valid <= '0;
          host.rsp_err   <= '0;
          state_reg      <= GAP;
        end
        GAP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sser_read_sequencer.md
SSER_READ_SEQUENCER -- requirements
Module: sser_read_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits shifted per read transaction, range 2..16.
REQ-002 SHALL have parameter SETUP_CYC, default 2: address-setup cycles before select, range 1..7.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester read request (bit0 = port 0, bit1 = port 1).
REQ-006 SHALL have port req_addr0 / req_addr1  in  10 each  requested bus address BA13..BA4.
REQ-007 SHALL have port req_ready  out  2  per-port accept strobe.
REQ-008 SHALL have port rsp_valid  out  2  per-port one-cycle response strobe.
REQ-009 SHALL have port rsp_err  out  2  per-port error flag, meaningful only with rsp_valid.
REQ-010 SHALL have port rsp_data  out  DATA_W  shared read data, meaningful only with a rsp_valid bit.
REQ-011 SHALL have port sser_n  out  1  serial-register select, active-low.
REQ-012 SHALL have port ba  out  10  bus address BA13..BA4.
REQ-013 SHALL have port br_w  out  1  bus read strobe, 1 = read.
REQ-014 SHALL have port sdrd  in  1  serial read data from the serial register.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT, DONE, GAP.
REQ-016 In IDLE, the arbiter SHALL pick one valid port; req_ready for that port SHALL be high for that single cycle, and the transfer on req_valid & req_ready SHALL capture the address and port index.
REQ-017 Arbitration SHALL be 2-way round-robin: if both ports are valid, the port not granted last wins; the last-grant pointer resets to favour port 0.
REQ-018 req_ready SHALL be low in every state except IDLE; a request dropped before acceptance SHALL start no bus cycle.
REQ-019 A captured address is legal only when BA13 = 0 and BA12 = 1; an illegal address SHALL go IDLE->DONE with rsp_err = 1 and rsp_data = 0, and SHALL leave sser_n, ba and br_w at idle values.
REQ-020 A legal address SHALL be accepted at edge k, then:
  - SETUP for cycles k+1..k+SETUP_CYC: ba = addr, br_w = 1, sser_n = 1.
  - SHIFT for DATA_W cycles: sser_n = 0, ba and br_w held.
REQ-021 In SHIFT, sdrd SHALL be sampled at the end of each cycle, MSB first: data <= {data[DATA_W-2:0], sdrd}.
REQ-022 DONE SHALL last one cycle:
  - rsp_valid[granted port] = 1.
  - rsp_err = 0 for a legal read.
  - sser_n = 1, ba = 0, br_w = 0.
REQ-023 GAP SHALL last one cycle with all bus outputs idle, then return to IDLE.
REQ-024 With defaults, a legal read SHALL give rsp_valid at k+11; the earliest next acceptance SHALL be at k+13. An illegal read SHALL give rsp_valid at k+1; the earliest next acceptance SHALL be at k+3.
REQ-025 Idle values: sser_n = 1, ba = 0, br_w = 0, req_ready = 0, rsp_valid = 0, rsp_err = 0.
REQ-026 rsp_data SHALL hold its last value until the next DONE.

Reset
REQ-027 rst_n low SHALL immediately force:
  - FSM state IDLE.
  - Arbiter pointer favouring port 0.
  - rsp_data = 0.
  - All other outputs at idle values.
REQ-028 Reset during SETUP or SHIFT SHALL abort with no response; the aborted request is lost.
REQ-029 The first acceptance after reset SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-030 Package sser_pkg SHALL hold the FSM state enum, legal-window constants (BA13 = 0, BA12 = 1) and port count 2.
REQ-031 Round-robin selection SHALL be a sub-module, sser_rr_arb, with inputs req[1:0] and advance and output grant[1:0]; the pointer updates only on acceptance.

Verification
REQ-032 Port 0 only, req_addr0 = 0x110, sdrd = 1,0,1,0,0,1,0,1 during SHIFT -> rsp_valid = 01 and rsp_data = 0xA5 at k+11; sser_n low exactly 8 cycles; ba = 0x110 throughout SETUP and SHIFT.
REQ-033 Both ports valid right after reset, each held until accepted -> port 0 accepted at k and port 1 at k+13; both valid again after that -> port 0 wins.
REQ-034 Port 1, req_addr1 = 0x210 (BA13 = 1) -> rsp_valid = 10, rsp_err = 10, rsp_data = 0 at k+1; sser_n stays 1 throughout.
REQ-035 rst_n low during the 4th SHIFT cycle -> sser_n = 1, ba = 0, br_w = 0 without waiting for a clock edge; no rsp_valid; a new request after release completes normally at its own k+11.
REQ-036 Port 0 held valid continuously, port 1 idle -> acceptances exactly 13 cycles apart, one rsp_valid per acceptance.
REQ-037 Port 0 drops req_valid while busy serving port 1 -> no acceptance on port 0; the bus stays idle after port 1's GAP.
